// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, round-function helpers and the core state type.
package sha1_pkg;

  localparam logic [31:0] H0_INIT = 32'h67452301;
  localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
  localparam logic [31:0] H2_INIT = 32'h98BADCFE;
  localparam logic [31:0] H3_INIT = 32'h10325476;
  localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [6:0] LAST_ROUND = 7'd79;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Round selector: Ch for 0..19, Parity for 20..39 and 60..79, Maj for 40..59.
  function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20) begin
      return (b & c) | (~b & d);
    end else if (t < 7'd40) begin
      return b ^ c ^ d;
    end else if (t < 7'd60) begin
      return (b & c) | (b & d) | (c & d);
    end else begin
      return b ^ c ^ d;
    end
  endfunction

  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    if (t < 7'd20) begin
      return K0;
    end else if (t < 7'd40) begin
      return K1;
    end else if (t < 7'd60) begin
      return K2;
    end else begin
      return K3;
    end
  endfunction

  function automatic logic [31:0] rol1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: consumes a..e, the schedule word and round index.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  t_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  logic [31:0] a_rol5;
  logic [31:0] f_val;
  logic [31:0] k_val;

  assign a_rol5 = {a_i[26:0], a_i[31:27]};
  assign f_val  = sha1_f(t_i, b_i, c_i, d_i);
  assign k_val  = sha1_k(t_i);

  assign a_o = a_rol5 + f_val + e_i + k_val + w_i;
  assign b_o = a_i;
  assign c_o = {b_i[1:0], b_i[31:2]};
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/sha1_core.sv
// SHA-1 compression engine: gathers 16 words, runs 80 rounds, folds into h0..h4.
module sha1_core
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] data,
  output logic [31:0] h0,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h4,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  t_q, t_d;
  logic        busy_q, busy_d;
  logic [31:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d, h3_q, h3_d, h4_q, h4_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;

  logic [31:0] w_q [16];
  logic        w_we;
  logic [3:0]  w_idx;
  logic [31:0] w_val;

  logic [3:0]  idx_m3, idx_m8, idx_m14;
  logic [31:0] w_sched;
  logic [31:0] w_cur;
  logic [31:0] rnd_a, rnd_b, rnd_c, rnd_d, rnd_e;

  // Circular schedule: slot t mod 16 still holds W[t-16] until overwritten this round.
  assign idx_m3  = t_q[3:0] - 4'd3;
  assign idx_m8  = t_q[3:0] - 4'd8;
  assign idx_m14 = t_q[3:0] - 4'd14;
  assign w_sched = rol1(w_q[idx_m3] ^ w_q[idx_m8] ^ w_q[idx_m14] ^ w_q[t_q[3:0]]);
  assign w_cur   = (t_q < 7'd16) ? w_q[t_q[3:0]] : w_sched;

  sha1_round u_round (
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .d_i (d_q),
    .e_i (e_q),
    .w_i (w_cur),
    .t_i (t_q),
    .a_o (rnd_a),
    .b_o (rnd_b),
    .c_o (rnd_c),
    .d_o (rnd_d),
    .e_o (rnd_e)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    busy_d  = busy_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
    h4_d    = h4_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    w_we    = 1'b0;
    w_idx   = cnt_q;
    w_val   = data;

    case (state_q)
      IDLE: begin
        if (wr) begin
          w_we  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            a_d     = h0_q;
            b_d     = h1_q;
            c_d     = h2_q;
            d_d     = h3_q;
            e_d     = h4_q;
            busy_d  = 1'b1;
            t_d     = 7'd0;
            state_d = ROUND;
          end
        end
      end

      ROUND: begin
        a_d = rnd_a;
        b_d = rnd_b;
        c_d = rnd_c;
        d_d = rnd_d;
        e_d = rnd_e;
        if (t_q >= 7'd16) begin
          w_we  = 1'b1;
          w_idx = t_q[3:0];
          w_val = w_sched;
        end
        if (t_q == LAST_ROUND) begin
          state_d = FINAL;
        end else begin
          t_d = t_q + 7'd1;
        end
      end

      FINAL: begin
        h0_d    = h0_q + a_q;
        h1_d    = h1_q + b_q;
        h2_d    = h2_q + c_q;
        h3_d    = h3_q + d_q;
        h4_d    = h4_q + e_q;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      t_q     <= 7'd0;
      busy_q  <= 1'b0;
      h0_q    <= H0_INIT;
      h1_q    <= H1_INIT;
      h2_q    <= H2_INIT;
      h3_q    <= H3_INIT;
      h4_q    <= H4_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      h4_q    <= h4_d;
    end
  end

  // Working variables and schedule are fully reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
    d_q <= d_d;
    e_q <= e_d;
    if (w_we) begin
      w_q[w_idx] <= w_val;
    end
  end

  assign h0   = h0_q;
  assign h1   = h1_q;
  assign h2   = h2_q;
  assign h3   = h3_q;
  assign h4   = h4_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sha1_core.sv
// Scoreboard bench for sha1_core: known vectors plus random chained blocks vs. a reference model.
module tb_sha1_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] data;
  logic [31:0] h0, h1, h2, h3, h4;
  logic        busy;

  sha1_core dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .data (data),
    .h0   (h0),
    .h1   (h1),
    .h2   (h2),
    .h3   (h3),
    .h4   (h4),
    .busy (busy)
  );

  always #5 clk = ~clk;

  localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] B_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {{15{32'h0}}, 32'h000001c0};

  wire [159:0] dig = {h0, h1, h2, h3, h4};

  int           errors = 0;
  int           checks = 0;
  logic [159:0] exp_q[$];
  logic         abort_pend = 1'b0;
  logic [159:0] mh;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Plain textbook SHA-1 compression of one block.
  function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        w[t] = blk[511 - 32*t -: 32];
      end else begin
        tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
        w[t] = {tmp[30:0], tmp[31]};
      end
    end
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_hold(input logic [31:0] d, input int n);
    wr   = 1'b1;
    data = d;
    repeat (n) @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] blk, input int maxgap, input int gap0,
                            input int hold_last);
    for (int i = 0; i < 16; i++) begin
      put_hold(blk[511 - 32*i -: 32], (i == 15) ? hold_last : 1);
      if (i == 0 && gap0 > 0) gap(gap0);
      else if (i < 15 && maxgap > 0) gap($urandom_range(maxgap, 0));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
    gap(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mh  = IV;
  endtask

  task automatic run_block(input logic [511:0] blk, input logic [159:0] exp_dig,
                           input int maxgap, input int gap0, input int hold_last);
    exp_q.push_back(exp_dig);
    mh = exp_dig;
    send_block(blk, maxgap, gap0, hold_last);
    wait_idle();
  endtask

  // Monitor: every falling edge of busy is a block completion (or an abort by reset).
  logic         prev_busy = 1'b0;
  int           bcyc = 0;
  logic [159:0] snap;
  logic         stable_ok = 1'b1;

  always @(negedge clk) begin
    logic [159:0] e;
    if (busy && !prev_busy) begin
      bcyc      = 1;
      snap      = dig;
      stable_ok = 1'b1;
    end else if (busy) begin
      bcyc++;
      if (dig !== snap) stable_ok = 1'b0;
    end else if (prev_busy) begin
      if (abort_pend) begin
        abort_pend = 1'b0;
        check("abort_iv", dig, IV);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: digest %0h with no expectation queued", dig);
      end else begin
        e = exp_q.pop_front();
        check("digest", dig, e);
        check("busy_cycles", 160'(bcyc), 160'd81);
        check("h_stable", {159'd0, stable_ok}, 160'd1);
      end
    end
    prev_busy = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [511:0] rblk;
    logic [159:0] e1;
    rst  = 1'b1;
    wr   = 1'b0;
    data = 32'h0;
    mh   = IV;
    gap(2);
    rst = 1'b0;

    check("reset_h", dig, IV);
    check("reset_busy", {159'd0, busy}, 160'd0);

    // "abc" with a single idle gap after the first word
    run_block(B_ABC, D_ABC, 0, 1, 1);

    // write strobe left high across the busy window must not disturb the block
    do_reset();
    run_block(B_ABC, D_ABC, 0, 0, 10);

    do_reset();
    run_block(B_EMPTY, D_EMPTY, 2, 0, 1);

    // two-block message chains from the intermediate hash
    do_reset();
    e1 = sha1_ref(IV, B_TWO1);
    run_block(B_TWO1, e1, 1, 0, 1);
    run_block(B_TWO2, D_TWO, 0, 0, 1);

    // abort in round 40, then the same "abc" block from a fresh IV
    do_reset();
    send_block(B_ABC, 0, 0, 1);
    gap(40);
    abort_pend = 1'b1;
    do_reset();
    gap(1);
    check("abort_busy", {159'd0, busy}, 160'd0);
    run_block(B_ABC, D_ABC, 0, 1, 1);

    // random blocks chained on the current state
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
      run_block(rblk, sha1_ref(mh, rblk), 3, 0, $urandom_range(4, 1));
    end

    gap(3);
    check("queue_drained", 160'(exp_q.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
